uart_rx_frame_asm: RTL and testbench
====================================

Name: uart_rx_frame_asm

Overview:
- Sits directly downstream of the UART byte receiver, upstream of the CORDIC core.
- Consumes validated bytes plus the per-byte parity error flag.
- Assembles sync-framed, XOR-checksummed multi-byte words (angle operands) and presents each word on a valid/ready interface.
- Drops malformed, stalled or overrun frames and reports them.

Parameters:
- DATA_W, 8, width of each received byte.
- BYTES_PER_WORD, 2, payload bytes per word; word width = DATA_W*BYTES_PER_WORD.
- SYNC_BYTE, 8'hA5, frame header value.
- TIMEOUT_TICKS, 1024, oversample ticks allowed between bytes inside a frame before abort.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- tick_i  in  1  oversample tick, same strobe that drives the UART receiver.
- rxd_byte_i  in  DATA_W  received byte.
- rxd_vld_i  in  1  one-cycle strobe: byte good (parity OK).
- rxd_err_i  in  1  one-cycle strobe: byte had a parity error.
- word_o  out  DATA_W*BYTES_PER_WORD  assembled word, LSB byte first on the wire.
- word_vld_o  out  1  word available.
- word_rdy_i  in  1  consumer accepts the word.
- frame_err_o  out  1  one-cycle pulse: frame aborted (bad checksum, parity error, or timeout).
- ovf_o  out  1  one-cycle pulse: byte dropped because the output was still held.

Behaviour:
- Reset values: word_o=0, word_vld_o=0, frame_err_o=0, ovf_o=0, state=IDLE, byte index=0, checksum=0, timeout count=0.
- Frame format: SYNC_BYTE, then payload B0..B(N-1), then CHK = XOR of B0..B(N-1). The sync byte is not included in CHK.
- State IDLE:
  - rxd_vld_i with byte==SYNC_BYTE -> COLLECT; clear index, checksum and timeout.
  - Any other byte, or rxd_err_i -> ignored, no error pulse.
- State COLLECT:
  - On rxd_vld_i: shift the byte into the word shift register (byte k lands at bits [k*DATA_W +: DATA_W]) and XOR it into the checksum.
  - After byte index N-1 -> CHECK.
  - A SYNC_BYTE value here is treated as data; there is no resync.
- State CHECK:
  - rxd_vld_i with byte == checksum -> OUT. word_o is loaded and word_vld_o=1 on the next edge, so latency is 1 cycle after the CHK strobe.
  - Mismatch -> IDLE with frame_err_o pulsed.
- State OUT:
  - word_o and word_vld_o are held stable until word_vld_o&&word_rdy_i; word_vld_o drops on the next edge -> IDLE.
  - Any byte strobe while word_vld_o=1 and word_rdy_i=0 is dropped and ovf_o pulses; state is unchanged.
  - A byte strobe in the handshake cycle is processed with IDLE rules.
- rxd_err_i in COLLECT or CHECK -> IDLE with frame_err_o pulsed. rxd_vld_i and rxd_err_i are never both high; if they are, rxd_err_i wins.
- Timeout (COLLECT and CHECK only):
  - Each tick_i increments the counter; each rxd_vld_i clears it.
  - When the counter reaches TIMEOUT_TICKS-1 on a tick -> IDLE with frame_err_o pulsed.
  - A byte strobe in the same cycle as the expiring tick wins: the byte is processed and the counter is cleared.
- Counter widths: $clog2(TIMEOUT_TICKS) and $clog2(BYTES_PER_WORD+1). No wrap is possible; state transitions reset the counters.
- Asynchronous reset mid-frame discards the partial word immediately. No pulses are emitted.

Optional Feature:
- Macro UART_FRAME_ERR_CNT_EN.
- With it defined: extra output err_cnt_o [15:0]. It increments on every frame_err_o and every ovf_o pulse, saturates at 16'hFFFF, and resets to 0. If both pulses occur in one cycle it increments by 1.
- Without it: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package uart_cordic_pkg holds:
  - The state enum frame_state_t {FR_IDLE, FR_COLLECT, FR_CHECK, FR_OUT}.
  - The default SYNC_BYTE localparam.
  - The checksum XOR fold function.
- One natural sub-module: uart_frame_timeout, the tick-driven inter-byte timeout counter with clear/enable inputs and an expire output.

Test Plan:
- Good frame, N=2: bytes A5,34,12,26 -> word_o=16'h1234 and word_vld_o=1 one cycle after the 26 strobe; word_rdy_i=1 -> word_vld_o=0 next cycle.
- Bad checksum: A5,34,12,27 -> one frame_err_o pulse, no word_vld_o. A following A5,01,00,01 -> word_o=16'h0001.
- Parity error mid-frame: A5,34, then rxd_err_i -> frame_err_o pulse, state IDLE; a subsequent good frame is accepted.
- Timeout: A5,34, then 1024 ticks with no byte -> frame_err_o pulse on tick 1024. Repeat with a byte landing on the expiring tick -> no error.
- Backpressure: good frame, word_rdy_i held 0, new A5 arrives -> ovf_o pulse, word_o stays 16'h1234. With UART_FRAME_ERR_CNT_EN, err_cnt_o=1.
- Reset: assert rst_ni=0 after A5,34 -> all outputs 0 immediately; after release, the frame A5,78,56,2E -> word_o=16'h5678.

Source files
------------

// File: rtl/uart_cordic_pkg.sv
// Shared types and helpers for the UART-to-CORDIC receive path.
package uart_cordic_pkg;

    typedef enum logic [1:0] {
        FR_IDLE    = 2'd0,
        FR_COLLECT = 2'd1,
        FR_CHECK   = 2'd2,
        FR_OUT     = 2'd3
    } frame_state_t;

    localparam int unsigned UART_DATA_W   = 8;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

    // One step of the running XOR checksum over the payload bytes.
    function automatic logic [31:0] chk_fold(input logic [31:0] acc, input logic [31:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout: counts oversample ticks while enabled, expires on the
// tick that finds the counter at TIMEOUT_TICKS-1.
module uart_frame_timeout #(
    parameter int unsigned TIMEOUT_TICKS = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_TICKS);

    logic [CNT_W-1:0] cnt_q;

    assign expire_c = en_i && tick_i && (cnt_q == CNT_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i || !en_i || expire_c) begin
            cnt_q <= '0;
        end else if (tick_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frame_asm.sv
// Assembles sync-framed, XOR-checksummed words from UART bytes onto valid/ready.
// Optional build macro UART_FRAME_ERR_CNT_EN adds a saturating error counter.
module uart_rx_frame_asm
    import uart_cordic_pkg::*;
#(
    parameter int unsigned         DATA_W         = UART_DATA_W,
    parameter int unsigned         BYTES_PER_WORD = 2,
    parameter logic [DATA_W-1:0]   SYNC_BYTE      = DATA_W'(SYNC_BYTE_DEF),
    parameter int unsigned         TIMEOUT_TICKS  = 1024
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               tick_i,
    input  logic [DATA_W-1:0]                  rxd_byte_i,
    input  logic                               rxd_vld_i,
    input  logic                               rxd_err_i,
    output logic [DATA_W*BYTES_PER_WORD-1:0]   word_o,
    output logic                               word_vld_o,
    input  logic                               word_rdy_i,
    output logic                               frame_err_o,
    output logic                               ovf_o
`ifdef UART_FRAME_ERR_CNT_EN
    ,
    output logic [15:0]                        err_cnt_o
`endif
);

    localparam int unsigned WORD_W = DATA_W * BYTES_PER_WORD;
    localparam int unsigned IDX_W  = $clog2(BYTES_PER_WORD + 1);

    frame_state_t        state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   chk_q, chk_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [WORD_W-1:0]   word_d;
    logic                word_vld_d;
    logic                frame_err_d;
    logic                ovf_d;
    logic                byte_ok;
    logic                to_en;
    logic                to_expire;

    // rxd_err_i dominates a simultaneous rxd_vld_i.
    assign byte_ok = rxd_vld_i && !rxd_err_i;
    assign to_en   = (state_q == FR_COLLECT) || (state_q == FR_CHECK);

    uart_frame_timeout #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .tick_i   (tick_i),
        .en_i     (to_en),
        .clr_i    (rxd_vld_i),
        .expire_c (to_expire)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= FR_IDLE;
            idx_q       <= '0;
            chk_q       <= '0;
            shreg_q     <= '0;
            word_o      <= '0;
            word_vld_o  <= 1'b0;
            frame_err_o <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            chk_q       <= chk_d;
            shreg_q     <= shreg_d;
            word_o      <= word_d;
            word_vld_o  <= word_vld_d;
            frame_err_o <= frame_err_d;
            ovf_o       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        chk_d       = chk_q;
        shreg_d     = shreg_q;
        word_d      = word_o;
        word_vld_d  = word_vld_o;
        frame_err_d = 1'b0;
        ovf_d       = 1'b0;

        case (state_q)
            FR_IDLE: begin
                if (byte_ok && (rxd_byte_i == SYNC_BYTE)) begin
                    state_d = FR_COLLECT;
                    idx_d   = '0;
                    chk_d   = '0;
                    shreg_d = '0;
                end
            end
            FR_COLLECT: begin
                if (rxd_err_i) begin
                    state_d     = FR_IDLE;
                    frame_err_d = 1'b1;
                end else if (byte_ok) begin
                    shreg_d[idx_q*DATA_W +: DATA_W] = rxd_byte_i;
                    chk_d = DATA_W'(chk_fold(32'(chk_q), 32'(rxd_byte_i)));
                    if (idx_q == IDX_W'(BYTES_PER_WORD - 1)) begin
                        state_d = FR_CHECK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (to_expire) begin
                    state_d     = FR_IDLE;
                    frame_err_d = 1'b1;
                end
            end
            FR_CHECK: begin
                if (rxd_err_i) begin
                    state_d     = FR_IDLE;
                    frame_err_d = 1'b1;
                end else if (byte_ok) begin
                    if (rxd_byte_i == chk_q) begin
                        state_d    = FR_OUT;
                        word_d     = shreg_q;
                        word_vld_d = 1'b1;
                    end else begin
                        state_d     = FR_IDLE;
                        frame_err_d = 1'b1;
                    end
                end else if (to_expire) begin
                    state_d     = FR_IDLE;
                    frame_err_d = 1'b1;
                end
            end
            FR_OUT: begin
                if (word_vld_o && word_rdy_i) begin
                    // Handshake cycle: release the word and apply idle rules to any byte.
                    word_vld_d = 1'b0;
                    state_d    = FR_IDLE;
                    if (byte_ok && (rxd_byte_i == SYNC_BYTE)) begin
                        state_d = FR_COLLECT;
                        idx_d   = '0;
                        chk_d   = '0;
                        shreg_d = '0;
                    end
                end else if (rxd_vld_i || rxd_err_i) begin
                    ovf_d = 1'b1;
                end
            end
            default: begin
                state_d = FR_IDLE;
            end
        endcase
    end

`ifdef UART_FRAME_ERR_CNT_EN
    // Saturating count of aborted frames and dropped bytes; coincident pulses count once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_o <= 16'd0;
        end else if ((frame_err_d || ovf_d) && (err_cnt_o != 16'hFFFF)) begin
            err_cnt_o <= err_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame_asm.sv
// Scoreboard bench for uart_rx_frame_asm: directed frames plus randomized traffic.
module tb_uart_rx_frame_asm;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic [7:0]  rxd_byte;
    logic        rxd_vld;
    logic        rxd_err;
    logic [15:0] word;
    logic        word_vld;
    logic        word_rdy;
    logic        frame_err;
    logic        ovf;
`ifdef UART_FRAME_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int act_ferr = 0;
    int act_ovf  = 0;
    int exp_ferr = 0;
    int exp_ovf  = 0;
    int exp_errcnt = 0;
    logic [15:0] exp_q[$];

    uart_rx_frame_asm dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .tick_i      (tick),
        .rxd_byte_i  (rxd_byte),
        .rxd_vld_i   (rxd_vld),
        .rxd_err_i   (rxd_err),
        .word_o      (word),
        .word_vld_o  (word_vld),
        .word_rdy_i  (word_rdy),
        .frame_err_o (frame_err),
        .ovf_o       (ovf)
`ifdef UART_FRAME_ERR_CNT_EN
        ,
        .err_cnt_o   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%h req=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // One clock of stimulus, applied just after the rising edge.
    task automatic cyc(input logic [7:0] b, input logic v, input logic e, input logic t);
        rxd_byte = b;
        rxd_vld  = v;
        rxd_err  = e;
        tick     = t;
        @(posedge clk);
        #1;
        rxd_vld = 1'b0;
        rxd_err = 1'b0;
        tick    = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        cyc(b, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_gap(input logic [7:0] b);
        idle($urandom_range(0, 2));
        send(b);
    endtask

    // Monitor: pops the expected word on every accepted transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) act_ferr++;
            if (ovf) act_ovf++;
            if (word_vld && word_rdy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected act=%h req=none t=%0t", word, $time);
                end else begin
                    check("sb_word", 32'(word), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [7:0] p0, p1, ck;
        int         kind;

        rst_n    = 1'b0;
        tick     = 1'b0;
        rxd_byte = 8'h00;
        rxd_vld  = 1'b0;
        rxd_err  = 1'b0;
        word_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_word", 32'(word), 32'h0);
        check("rst_vld", 32'(word_vld), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Good frame with one-cycle output latency.
        send(8'hA5); send(8'h34); send(8'h12);
        exp_q.push_back(16'h1234);
        send(8'h26);
        check("good_vld", 32'(word_vld), 32'h1);
        check("good_word", 32'(word), 32'h1234);
        idle(1);
        check("good_vld_drop", 32'(word_vld), 32'h0);
        idle(2);

        // Bad checksum, then a good frame.
        send(8'hA5); send(8'h34); send(8'h12); send(8'h27);
        check("badchk_ferr", 32'(frame_err), 32'h1);
        check("badchk_vld", 32'(word_vld), 32'h0);
        exp_ferr++; exp_errcnt++;
        idle(1);
        check("badchk_pulse_end", 32'(frame_err), 32'h0);
        send(8'hA5); send(8'h01); send(8'h00);
        exp_q.push_back(16'h0001);
        send(8'h01);
        idle(2);

        // Parity error mid-frame.
        send(8'hA5); send(8'h34);
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
        check("parity_ferr", 32'(frame_err), 32'h1);
        exp_ferr++; exp_errcnt++;
        idle(1);
        send(8'hA5); send(8'hCD); send(8'hAB);
        exp_q.push_back(16'hABCD);
        send(8'h66);
        idle(2);

        // Timeout expires on the 1024th tick.
        send(8'hA5); send(8'h34);
        repeat (1023) cyc(8'h00, 1'b0, 1'b0, 1'b1);
        check("timeout_early", 32'(frame_err), 32'h0);
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        check("timeout_ferr", 32'(frame_err), 32'h1);
        exp_ferr++; exp_errcnt++;
        idle(2);

        // Byte on the expiring tick wins.
        send(8'hA5); send(8'h34);
        repeat (1023) cyc(8'h00, 1'b0, 1'b0, 1'b1);
        cyc(8'h12, 1'b1, 1'b0, 1'b1);
        check("timeout_byte_wins", 32'(frame_err), 32'h0);
        exp_q.push_back(16'h1234);
        send(8'h26);
        idle(2);

        // Backpressure: a byte while the word is held is dropped.
        word_rdy = 1'b0;
        send(8'hA5); send(8'h34); send(8'h12);
        exp_q.push_back(16'h1234);
        send(8'h26);
        idle(1);
        send(8'hA5);
        check("bp_ovf", 32'(ovf), 32'h1);
        check("bp_word_held", 32'(word), 32'h1234);
        check("bp_vld_held", 32'(word_vld), 32'h1);
        exp_ovf++; exp_errcnt++;
        idle(1);
        check("bp_ovf_end", 32'(ovf), 32'h0);
`ifdef UART_FRAME_ERR_CNT_EN
        check("bp_err_cnt", 32'(err_cnt), 32'(exp_errcnt));
`endif
        word_rdy = 1'b1;
        idle(2);
        check("bp_released", 32'(word_vld), 32'h0);

        // Reset mid-frame discards the partial word.
        send(8'hA5); send(8'h34);
        rst_n = 1'b0;
        #1;
        check("mid_rst_word", 32'(word), 32'h0);
        check("mid_rst_vld", 32'(word_vld), 32'h0);
        check("mid_rst_ferr", 32'(frame_err), 32'h0);
        check("mid_rst_ovf", 32'(ovf), 32'h0);
`ifdef UART_FRAME_ERR_CNT_EN
        check("mid_rst_err_cnt", 32'(err_cnt), 32'h0);
`endif
        exp_errcnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        send(8'hA5); send(8'h78); send(8'h56);
        exp_q.push_back(16'h5678);
        send(8'h2E);
        check("post_rst_word", 32'(word), 32'h5678);
        idle(2);

        // Randomized traffic: good/bad frames, idle junk and idle parity errors.
        for (int it = 0; it < 80; it++) begin
            kind = $urandom_range(0, 3);
            p0 = 8'($urandom);
            p1 = 8'($urandom);
            ck = p0 ^ p1;
            case (kind)
                0, 1: begin
                    if (kind == 1) begin
                        ck = ck ^ 8'($urandom_range(1, 255));
                        exp_ferr++; exp_errcnt++;
                    end else begin
                        exp_q.push_back({p1, p0});
                    end
                    send_gap(8'hA5); send_gap(p0); send_gap(p1); send_gap(ck);
                end
                2: send_gap((p0 == 8'hA5) ? 8'h5A : p0);
                default: begin
                    idle($urandom_range(0, 2));
                    cyc(p0, 1'b0, 1'b1, 1'b0);
                end
            endcase
        end
        idle(4);

        check("end_queue_empty", 32'(exp_q.size()), 32'h0);
        check("end_ferr_count", 32'(act_ferr), 32'(exp_ferr));
        check("end_ovf_count", 32'(act_ovf), 32'(exp_ovf));
`ifdef UART_FRAME_ERR_CNT_EN
        check("end_err_cnt", 32'(err_cnt), 32'(exp_errcnt));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
